// File: rtl/wb_commit_pkg.sv
// Shared types and helpers for the write-back commit stage.
package wb_commit_pkg;

    localparam int XLEN  = 64;
    localparam int PID_W = 2;

    typedef logic [PID_W-1:0] pid_t;

    // One held write-back result.
    typedef struct packed {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        pid_t            pid;
    } wb_entry_t;

    // Program-order successor; wraps modulo 2^PID_W.
    function automatic pid_t pid_next(input pid_t pid);
        return pid + pid_t'(1);
    endfunction

endpackage

// File: rtl/wb_commit_slot.sv
// One-entry holding slot for a single way: captures a result when free
// (or when its current occupant commits this cycle) and empties on commit,
// flush or reset.
module wb_commit_slot
    import wb_commit_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      in_valid,
    input  wb_entry_t in_entry,
    input  logic      commit,
    output logic      ready,
    output logic      slot_v,
    output wb_entry_t slot
);

    logic capture;

    // A slot committing this cycle is free again at the edge.
    assign ready   = ~slot_v | commit;
    assign capture = in_valid & ready;

    // Occupancy: reset beats flush, flush drops the input, capture beats clear.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v <= 1'b0;
        end else if (flush) begin
            slot_v <= 1'b0;
        end else if (capture) begin
            slot_v <= 1'b1;
        end else if (commit) begin
            slot_v <= 1'b0;
        end
    end

    // Payload register, loaded on every accepted capture.
    // NOTE: payload is deliberately not reset; slot_v alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (!reset && !flush && capture) begin
            slot <= in_entry;
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: retires way0/way1 results in pID program order,
// up to two per cycle, onto the two register-file write ports.
module wb_commit_unit
    import wb_commit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,

    input  logic             way0_valid_i,
    output logic             way0_ready_o,
    input  logic             way0_rdWriteEnable_i,
    input  logic [4:0]       way0_rdAddr_i,
    input  logic [XLEN-1:0]  way0_rdData_i,
    input  logic [PID_W-1:0] way0_pID_i,

    input  logic             way1_valid_i,
    output logic             way1_ready_o,
    input  logic             way1_rdWriteEnable_i,
    input  logic [4:0]       way1_rdAddr_i,
    input  logic [XLEN-1:0]  way1_rdData_i,
    input  logic [PID_W-1:0] way1_pID_i,

    input  logic             flush_i,
    input  logic [PID_W-1:0] flushPID_i,

    output logic             rfWe0_o,
    output logic             rfWe1_o,
    output logic [4:0]       rfAddr0_o,
    output logic [4:0]       rfAddr1_o,
    output logic [XLEN-1:0]  rfData0_o,
    output logic [XLEN-1:0]  rfData1_o,
    output logic [1:0]       retireCnt_o,
    output logic             pidErr_o
);

    wb_entry_t in0, in1;
    wb_entry_t s0, s1;
    logic      s0_v, s1_v;
    logic      commit0, commit1;
    pid_t      exp_pid;

    logic       first0, first1, second0, second1;
    logic       p0_v, p1_v;
    wb_entry_t  p0, p1;
    logic       we0_n, we1_n;
    logic [1:0] cnt_n;
    logic       dup_pid;

    assign in0 = '{way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i};
    assign in1 = '{way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i};

    wb_commit_slot u_slot0 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .in_valid (way0_valid_i),
        .in_entry (in0),
        .commit   (commit0),
        .ready    (way0_ready_o),
        .slot_v   (s0_v),
        .slot     (s0)
    );

    wb_commit_slot u_slot1 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .in_valid (way1_valid_i),
        .in_entry (in1),
        .commit   (commit1),
        .ready    (way1_ready_o),
        .slot_v   (s1_v),
        .slot     (s1)
    );

    // Ordering decision and write-port mapping, from held slots only.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        first0  = 1'b0;
        first1  = 1'b0;
        second0 = 1'b0;
        second1 = 1'b0;
        p0      = '0;
        p1      = '0;
        p0_v    = 1'b0;
        p1_v    = 1'b0;
        we0_n   = 1'b0;
        we1_n   = 1'b0;
        cnt_n   = 2'd0;

        // Way0 wins a duplicate pID; way1 then cannot match expPID+1.
        first0 = s0_v && (s0.pid == exp_pid);
        first1 = s1_v && (s1.pid == exp_pid) && !first0;
        second1 = first0 && s1_v && (s1.pid == pid_next(exp_pid));
        second0 = first1 && s0_v && (s0.pid == pid_next(exp_pid));

        p0_v = first0 | first1;
        p1_v = second0 | second1;
        if (first0) begin
            p0 = s0;
        end else if (first1) begin
            p0 = s1;
        end
        if (second1) begin
            p1 = s1;
        end else if (second0) begin
            p1 = s0;
        end

        we0_n = p0_v && p0.we && (p0.addr != 5'd0);
        we1_n = p1_v && p1.we && (p1.addr != 5'd0);
        // The younger result on port1 wins a same-register collision.
        if (we0_n && we1_n && (p0.addr == p1.addr)) begin
            we0_n = 1'b0;
        end

        cnt_n = {1'b0, p0_v} + {1'b0, p1_v};
    end

    assign commit0 = first0 | second0;
    assign commit1 = first1 | second1;
    assign dup_pid = s0_v && s1_v && (s0.pid == s1.pid);

    // Registered write ports and retire count; flush emits nothing.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rfWe0_o     <= 1'b0;
            rfWe1_o     <= 1'b0;
            rfAddr0_o   <= '0;
            rfAddr1_o   <= '0;
            rfData0_o   <= '0;
            rfData1_o   <= '0;
            retireCnt_o <= 2'd0;
        end else begin
            rfWe0_o     <= we0_n;
            rfWe1_o     <= we1_n;
            rfAddr0_o   <= p0.addr;
            rfAddr1_o   <= p1.addr;
            rfData0_o   <= p0.data;
            rfData1_o   <= p1.data;
            retireCnt_o <= cnt_n;
        end
    end

    // Expected-pID counter: re-synced by flush, otherwise advanced by retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_pid <= '0;
        end else if (flush_i) begin
            exp_pid <= flushPID_i;
        end else begin
            exp_pid <= exp_pid + pid_t'(cnt_n);
        end
    end

    // Sticky duplicate-pID flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pidErr_o <= 1'b0;
        end else if (dup_pid) begin
            pidErr_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed scenarios followed by
// randomized traffic, compared against a queue-free behavioural model that
// retires by searching held results for the next program-order ID.
module tb_wb_commit_unit;
    import wb_commit_pkg::*;

    localparam int NPID = 2 ** PID_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             v    [2];
    logic             we   [2];
    logic [4:0]       addr [2];
    logic [XLEN-1:0]  data [2];
    logic [PID_W-1:0] pid  [2];
    logic             rdy  [2];
    logic             flush;
    logic [PID_W-1:0] flush_pid;
    logic             rf_we0, rf_we1, pid_err;
    logic [4:0]       rf_addr0, rf_addr1;
    logic [XLEN-1:0]  rf_data0, rf_data1;
    logic [1:0]       retire_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit              known = 0;
    bit              mv    [2];
    bit              mwe   [2];
    logic [4:0]      maddr [2];
    logic [XLEN-1:0] mdata [2];
    int              mpid  [2];
    int              mexp;
    bit              merr;

    // Expected registered outputs
    bit              x_we0, x_we1;
    logic [4:0]      x_addr0, x_addr1;
    logic [XLEN-1:0] x_data0, x_data1;
    int              x_cnt;

    wb_commit_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .way0_valid_i         (v[0]),
        .way0_ready_o         (rdy[0]),
        .way0_rdWriteEnable_i (we[0]),
        .way0_rdAddr_i        (addr[0]),
        .way0_rdData_i        (data[0]),
        .way0_pID_i           (pid[0]),
        .way1_valid_i         (v[1]),
        .way1_ready_o         (rdy[1]),
        .way1_rdWriteEnable_i (we[1]),
        .way1_rdAddr_i        (addr[1]),
        .way1_rdData_i        (data[1]),
        .way1_pID_i           (pid[1]),
        .flush_i              (flush),
        .flushPID_i           (flush_pid),
        .rfWe0_o              (rf_we0),
        .rfWe1_o              (rf_we1),
        .rfAddr0_o            (rf_addr0),
        .rfAddr1_o            (rf_addr1),
        .rfData0_o            (rf_data0),
        .rfData1_o            (rf_data1),
        .retireCnt_o          (retire_cnt),
        .pidErr_o             (pid_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic set_way(input int w, input bit valid, input bit wen, input int a,
                           input logic [XLEN-1:0] d, input int p);
        v[w]    = valid;
        we[w]   = wen;
        addr[w] = 5'(a);
        data[w] = d;
        pid[w]  = PID_W'(p);
    endtask

    task automatic idle();
        v[0]  = 1'b0;
        v[1]  = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
    endtask

    // One clock: predict, check ready before the edge, advance model, check outputs after it.
    task automatic step();
        int  used [2];
        int  pick [2];
        int  n;
        int  e;
        int  f;
        bit  mrdy [2];
        bit  acc  [2];
        bit  dup;

        #1;
        used = '{0, 0};
        pick = '{-1, -1};
        n    = 0;
        e    = mexp;
        for (int k = 0; k < 2; k++) begin
            f = -1;
            for (int w = 0; w < 2; w++)
                if (f < 0 && used[w] == 0 && mv[w] && mpid[w] == e) f = w;
            if (f >= 0) begin
                used[f] = 1;
                pick[k] = f;
                n++;
                e = (e + 1) % NPID;
            end
        end
        for (int w = 0; w < 2; w++) mrdy[w] = !mv[w] || (used[w] != 0);
        if (known) begin
            check("way0_ready", rdy[0], mrdy[0]);
            check("way1_ready", rdy[1], mrdy[1]);
        end
        dup = mv[0] && mv[1] && (mpid[0] == mpid[1]);

        if (reset) begin
            mv = '{0, 0};
            mexp = 0;
            merr = 0;
            {x_we0, x_we1, x_addr0, x_addr1, x_data0, x_data1} = '0;
            x_cnt = 0;
        end else if (flush) begin
            mv = '{0, 0};
            mexp = int'(flush_pid);
            merr = merr | dup;
            {x_we0, x_we1, x_addr0, x_addr1, x_data0, x_data1} = '0;
            x_cnt = 0;
        end else begin
            merr  = merr | dup;
            x_cnt = n;
            x_we0 = 0; x_addr0 = '0; x_data0 = '0;
            x_we1 = 0; x_addr1 = '0; x_data1 = '0;
            if (pick[0] >= 0) begin
                x_we0   = mwe[pick[0]] && maddr[pick[0]] != 0;
                x_addr0 = maddr[pick[0]];
                x_data0 = mdata[pick[0]];
            end
            if (pick[1] >= 0) begin
                x_we1   = mwe[pick[1]] && maddr[pick[1]] != 0;
                x_addr1 = maddr[pick[1]];
                x_data1 = mdata[pick[1]];
            end
            if (x_we0 && x_we1 && x_addr0 == x_addr1) x_we0 = 0;
            mexp = e;
            for (int w = 0; w < 2; w++) begin
                acc[w] = v[w] && mrdy[w];
                if (acc[w]) begin
                    mv[w]    = 1;
                    mwe[w]   = we[w];
                    maddr[w] = addr[w];
                    mdata[w] = data[w];
                    mpid[w]  = int'(pid[w]);
                end else if (used[w] != 0) begin
                    mv[w] = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        if (reset) known = 1;
        if (known) begin
            check("rfWe0", rf_we0, x_we0);
            check("rfWe1", rf_we1, x_we1);
            check("rfAddr0", rf_addr0, x_addr0);
            check("rfAddr1", rf_addr1, x_addr1);
            check("rfData0", rf_data0, x_data0);
            check("rfData1", rf_data1, x_data1);
            check("retireCnt", retire_cnt, x_cnt);
            check("pidErr", pid_err, merr);
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        set_way(0, 0, 0, 0, '0, 0);
        set_way(1, 0, 0, 0, '0, 0);
        flush_pid = '0;
        mexp = 0;
        merr = 0;
        mv = '{0, 0};
        #2;

        // Reset state
        do_reset();
        check("rst_cnt", retire_cnt, 0);
        check("rst_err", pid_err, 0);
        check("rst_we0", rf_we0, 0);

        // In-order dual retire
        set_way(0, 1, 1, 5, 64'hA, 0);
        set_way(1, 1, 1, 6, 64'hB, 1);
        step();
        idle();
        step();
        check("dual_we0", rf_we0, 1);
        check("dual_we1", rf_we1, 1);
        check("dual_addr0", rf_addr0, 5);
        check("dual_data0", rf_data0, 64'hA);
        check("dual_data1", rf_data1, 64'hB);
        check("dual_cnt", retire_cnt, 2);

        // Out-of-order arrival
        do_reset();
        set_way(1, 1, 1, 8, 64'h81, 1);
        step();
        idle();
        check("ooo_ready1_c1", rdy[1], 0);
        step();
        check("ooo_ready1_c2", rdy[1], 0);
        set_way(0, 1, 1, 9, 64'h90, 0);
        step();
        idle();
        step();
        check("ooo_cnt", retire_cnt, 2);
        check("ooo_data1", rf_data1, 64'h81);

        // Same-address dual commit with pID wrap (expPID is 2 here)
        set_way(0, 1, 1, 7, 64'h11, 2);
        set_way(1, 1, 1, 7, 64'h22, 3);
        step();
        idle();
        step();
        check("same_we0", rf_we0, 0);
        check("same_we1", rf_we1, 1);
        check("same_data1", rf_data1, 64'h22);

        // x0 retire, proves expPID wrapped to 0
        set_way(0, 1, 1, 0, 64'h5, 0);
        step();
        idle();
        step();
        check("x0_we0", rf_we0, 0);
        check("x0_cnt", retire_cnt, 1);

        // Flush with pID re-sync (expPID is 1 here)
        set_way(1, 1, 1, 4, 64'h44, 3);
        step();
        idle();
        step();
        check("fl_held_cnt", retire_cnt, 0);
        flush = 1'b1;
        flush_pid = 2'd2;
        step();
        idle();
        check("fl_we1", rf_we1, 0);
        check("fl_cnt", retire_cnt, 0);
        check("fl_ready1", rdy[1], 1);
        set_way(0, 1, 1, 10, 64'h33, 2);
        step();
        idle();
        step();
        check("fl_after_we0", rf_we0, 1);
        check("fl_after_data0", rf_data0, 64'h33);
        check("fl_after_cnt", retire_cnt, 1);

        // Duplicate pID
        do_reset();
        set_way(0, 1, 1, 3, 64'hD0, 0);
        set_way(1, 1, 1, 4, 64'hD1, 0);
        step();
        idle();
        step();
        check("dup_err", pid_err, 1);
        check("dup_cnt", retire_cnt, 1);
        check("dup_data0", rf_data0, 64'hD0);
        step();
        step();
        check("dup_err_sticky", pid_err, 1);
        check("dup_way1_held", rdy[1], 0);
        do_reset();
        check("dup_err_clr", pid_err, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int w = 0; w < 2; w++)
                set_way(w, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                        int'($urandom_range(0, 3)), {$urandom, $urandom},
                        int'($urandom_range(0, NPID - 1)));
            flush     = ($urandom_range(0, 29) == 0);
            flush_pid = PID_W'($urandom_range(0, NPID - 1));
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
